// File: rtl/rf_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package rf_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] ZERO_ADDR = '0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file, flattened per port.
interface register_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic                     alloc_conflict;
  logic                     pending_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, alloc_conflict, pending_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, alloc_conflict, pending_any
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: register-0 handling, write bypass and busy masking.
module rf_read_port
  import rf_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        word,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     pend,
  output logic [DATA_W-1:0]        data,
  output logic                     busy
);

  logic              hit;
  logic [DATA_W-1:0] fwd;

  // Ascending scan so the highest-index matching write port is the one forwarded.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    if (BYPASS != 0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
          hit = 1'b1;
          fwd = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    data = hit ? fwd : word;
    busy = pend & ~hit;
    if ((ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR))) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with per-register pending bits for in-flight producers.
module register_file_sb
  import rf_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               reset,
  register_file_sb_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic              alloc_nonzero;

  assign alloc_nonzero = (ZERO_REG == 0) || (bus.alloc_addr != ADDR_W'(ZERO_ADDR));

  // Writes clear before the alloc sets, so a same-cycle alloc+write leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (bus.flush) begin
      pending_next = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j]) begin
        pending_next[bus.wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (bus.alloc_en) begin
      pending_next[bus.alloc_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_next[0] = 1'b0;
    end
  end

  // Ascending write ports with non-blocking updates: the last (highest) port wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] &&
            !((ZERO_REG != 0) && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_ADDR)))) begin
          regs[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending             <= '0;
      bus.alloc_conflict  <= 1'b0;
      bus.pending_any     <= 1'b0;
    end else begin
      pending             <= pending_next;
      bus.alloc_conflict  <= bus.alloc_en & pending[bus.alloc_addr] & ~bus.flush & alloc_nonzero;
      bus.pending_any     <= |pending_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .addr    (addr),
      .word    (regs[addr]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .pend    (pending[addr]),
      .data    (bus.rd_data[k*DATA_W +: DATA_W]),
      .busy    (bus.rd_busy[k])
    );
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench: a bypassing and a non-bypassing instance share stimulus.
module tb_register_file_sb;

  logic clk;
  logic reset;
  int   num_asserts;
  int   num_fail;

  register_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bb ();
  register_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) nb ();

  assign nb.rd_addr    = bb.rd_addr;
  assign nb.wr_en      = bb.wr_en;
  assign nb.wr_addr    = bb.wr_addr;
  assign nb.wr_data    = bb.wr_data;
  assign nb.alloc_en   = bb.alloc_en;
  assign nb.alloc_addr = bb.alloc_addr;
  assign nb.flush      = bb.flush;

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
    dut_byp (.clk(clk), .reset(reset), .bus(bb));

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
    dut_nob (.clk(clk), .reset(reset), .bus(nb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] wa1, input logic [4:0] wa0,
                               input logic [31:0] wd1, input logic [31:0] wd0,
                               input logic aen, input logic [4:0] aaddr, input logic fl,
                               input logic [4:0] ra1, input logic [4:0] ra0);
    bb.wr_en      = wen;
    bb.wr_addr    = {wa1, wa0};
    bb.wr_data    = {wd1, wd0};
    bb.alloc_en   = aen;
    bb.alloc_addr = aaddr;
    bb.flush      = fl;
    bb.rd_addr    = {ra1, ra0};
    #1;
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra0);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, ra1, ra0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_asserts++;
    assert (observed === expected)
    else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    num_asserts = 0;
    num_fail    = 0;
    reset       = 1'b0;
    idle(5'd0, 5'd0);
    step();
    reset = 1'b1;
    #1;
    checkOutput("reset_pending_any", {31'b0, bb.pending_any}, 32'h0);
    checkOutput("reset_alloc_conflict", {31'b0, bb.alloc_conflict}, 32'h0);

    for (int r = 1; r < 32; r++) begin
      idle(5'(r), 5'(r));
      checkOutput("reset_rd0", bb.rd_data[31:0], 32'h0);
      checkOutput("reset_rd1", bb.rd_data[63:32], 32'h0);
      checkOutput("reset_busy", {30'b0, bb.rd_busy}, 32'h0);
    end
    step();

    // Both write ports to r5: port 1 wins.
    applyStimulus(2'b11, 5'd5, 5'd5, 32'h1234_5678, 32'hA5A5_0000, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    step();
    idle(5'd5, 5'd5);
    checkOutput("wr_prio_byp", bb.rd_data[31:0], 32'h1234_5678);
    checkOutput("wr_prio_nob", nb.rd_data[63:32], 32'h1234_5678);

    // Independent ports, then bypass on r7.
    applyStimulus(2'b11, 5'd2, 5'd7, 32'h0000_0002, 32'h1111_2222, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    step();
    applyStimulus(2'b01, 5'd0, 5'd7, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd2, 5'd7);
    checkOutput("bypass_data", bb.rd_data[31:0], 32'hDEAD_BEEF);
    checkOutput("bypass_busy", {31'b0, bb.rd_busy[0]}, 32'h0);
    checkOutput("nobypass_data", nb.rd_data[31:0], 32'h1111_2222);
    checkOutput("port1_r2", bb.rd_data[63:32], 32'h0000_0002);
    step();
    idle(5'd7, 5'd7);
    checkOutput("r7_after_wr_nob", nb.rd_data[31:0], 32'hDEAD_BEEF);
    checkOutput("r7_after_wr_byp", bb.rd_data[63:32], 32'hDEAD_BEEF);

    // Bypass priority when both ports hit the read address.
    applyStimulus(2'b11, 5'd10, 5'd10, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
    checkOutput("bypass_prio", bb.rd_data[63:32], 32'hBBBB_BBBB);
    checkOutput("nobypass_prio", nb.rd_data[63:32], 32'h0);
    step();

    // Alloc r3, realloc for conflict pulse, then write clears.
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
    step();
    idle(5'd0, 5'd3);
    checkOutput("alloc_no_conflict", {31'b0, bb.alloc_conflict}, 32'h0);
    checkOutput("alloc_pending_any", {31'b0, bb.pending_any}, 32'h1);
    checkOutput("alloc_busy_byp", {31'b0, bb.rd_busy[0]}, 32'h1);
    checkOutput("alloc_busy_nob", {31'b0, nb.rd_busy[0]}, 32'h1);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
    step();
    idle(5'd0, 5'd3);
    checkOutput("conflict_pulse", {31'b0, bb.alloc_conflict}, 32'h1);
    step();
    checkOutput("conflict_drop", {31'b0, bb.alloc_conflict}, 32'h0);
    checkOutput("still_busy", {31'b0, bb.rd_busy[0]}, 32'h1);
    applyStimulus(2'b01, 5'd0, 5'd3, 32'h0, 32'h0000_0042, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    checkOutput("wr_busy_mask_byp", {31'b0, bb.rd_busy[0]}, 32'h0);
    checkOutput("wr_busy_keep_nob", {31'b0, nb.rd_busy[0]}, 32'h1);
    step();
    idle(5'd0, 5'd3);
    checkOutput("wb_busy_clear", {31'b0, nb.rd_busy[0]}, 32'h0);
    checkOutput("wb_data", nb.rd_data[31:0], 32'h0000_0042);
    checkOutput("wb_pending_any", {31'b0, bb.pending_any}, 32'h0);

    // Alloc + write same register stays pending; flush clears but keeps data.
    applyStimulus(2'b10, 5'd9, 5'd0, 32'h0000_9999, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    step();
    idle(5'd0, 5'd9);
    checkOutput("alloc_wr_busy", {31'b0, bb.rd_busy[0]}, 32'h1);
    checkOutput("alloc_wr_data", bb.rd_data[31:0], 32'h0000_9999);
    checkOutput("alloc_wr_pend_any", {31'b0, bb.pending_any}, 32'h1);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd9);
    step();
    idle(5'd0, 5'd9);
    checkOutput("flush_pend_any", {31'b0, bb.pending_any}, 32'h0);
    checkOutput("flush_busy", {31'b0, bb.rd_busy[0]}, 32'h0);
    checkOutput("flush_keeps_data", bb.rd_data[31:0], 32'h0000_9999);

    // Flush with alloc: only the new register remains; flush masks a conflict.
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    step();
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd0, 5'd0);
    step();
    idle(5'd12, 5'd9);
    checkOutput("flush_alloc_old", {31'b0, bb.rd_busy[0]}, 32'h0);
    checkOutput("flush_alloc_new", {31'b0, bb.rd_busy[1]}, 32'h1);
    checkOutput("flush_alloc_any", {31'b0, bb.pending_any}, 32'h1);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd0, 5'd0);
    step();
    idle(5'd12, 5'd0);
    checkOutput("flush_masks_conflict", {31'b0, bb.alloc_conflict}, 32'h0);
    checkOutput("flush_realloc_busy", {31'b0, bb.rd_busy[1]}, 32'h1);
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
    step();

    // Register 0 ignores writes and allocs.
    applyStimulus(2'b01, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("r0_bypass_zero", bb.rd_data[31:0], 32'h0);
    step();
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("r0_data", nb.rd_data[31:0], 32'h0);
    checkOutput("r0_busy", {31'b0, bb.rd_busy[0]}, 32'h0);
    checkOutput("r0_pend_any", {31'b0, bb.pending_any}, 32'h0);
    step();
    idle(5'd0, 5'd0);
    checkOutput("r0_no_conflict", {31'b0, bb.alloc_conflict}, 32'h0);

    // Reset mid-stream with pending bits and stored data.
    applyStimulus(2'b01, 5'd0, 5'd20, 32'h0, 32'h0000_1234, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
    step();
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0);
    step();
    idle(5'd4, 5'd20);
    checkOutput("pre_reset_pend_any", {31'b0, bb.pending_any}, 32'h1);
    checkOutput("pre_reset_busy", {31'b0, bb.rd_busy[1]}, 32'h1);
    reset = 1'b0;
    applyStimulus(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd4, 5'd20);
    step();
    reset = 1'b1;
    idle(5'd4, 5'd20);
    checkOutput("mid_reset_pend_any", {31'b0, bb.pending_any}, 32'h0);
    checkOutput("mid_reset_busy", {30'b0, bb.rd_busy}, 32'h0);
    checkOutput("mid_reset_data", nb.rd_data[31:0], 32'h0);
    checkOutput("mid_reset_conflict", {31'b0, bb.alloc_conflict}, 32'h0);
    idle(5'd6, 5'd5);
    checkOutput("mid_reset_r6_busy", {31'b0, bb.rd_busy[1]}, 32'h0);
    checkOutput("mid_reset_r5_data", bb.rd_data[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fail);
    $finish;
  end

endmodule
